// File: rtl/rv_pkg.sv
// rv_pkg: constants shared by the memory port arbiter and its helpers.
// FSM encoding, bus op codes and the fetch load-size code.
package rv_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_D_ADDR = 3'd1;
  localparam logic [2:0] ST_D_RESP = 3'd2;
  localparam logic [2:0] ST_F_ADDR = 3'd3;
  localparam logic [2:0] ST_F_RESP = 3'd4;

  localparam logic [2:0] RD_LW = 3'b010;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  function automatic logic st_addr(
    input logic [2:0] s
  );
    return (s == ST_D_ADDR) || (s == ST_F_ADDR);
  endfunction

  function automatic logic st_resp(
    input logic [2:0] s
  );
    return (s == ST_D_RESP) || (s == ST_F_RESP);
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: saturating wait counter with clear, enable
// and an expired flag once LIMIT cycles have been counted.
module mem_arb_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and data ports.
// Optional one-entry fetch buffer enabled by MEM_ARB_FETCH_BUF_EN.
module mem_port_arbiter
  import rv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  input  logic              i_d_rd_en,
  input  logic              i_d_wr_en,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [1:0]        i_d_wr_type,
  input  logic [2:0]        i_d_rd_type,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_valid,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [1:0]        o_mem_wr_type,
  output logic [2:0]        o_mem_rd_type,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_bus_err
);

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        wt_q, wt_d;
  logic [2:0]        rt_q, rt_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic [DATA_W-1:0] frd_q, frd_d;
  logic              dv_q, dv_d;
  logic              fv_q, fv_d;
  logic              err_q, err_d;

  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_exp;
  logic              d_req;
  logic              pulse;
  logic              fb_hit;
  logic [DATA_W-1:0] fb_data;

  assign d_req  = i_d_rd_en | i_d_wr_en;
  assign pulse  = dv_q | fv_q;
  assign tmo_en = st_addr(state_q) | st_resp(state_q);

  mem_arb_timeout #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

`ifdef MEM_ARB_FETCH_BUF_EN
  logic              fbv_q;
  logic [ADDR_W-1:0] fbt_q;
  logic [DATA_W-1:0] fbd_q;
  logic              fb_fill;
  logic              fb_kill;

  assign fb_hit  = fbv_q && (i_if_addr == fbt_q);
  assign fb_data = fbd_q;
  assign fb_fill = (state_q == ST_F_RESP) && i_mem_rvalid;
  assign fb_kill = (state_q == ST_IDLE) && !pulse
                && i_d_wr_en && (i_d_addr == fbt_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fbv_q <= 1'b0;
      fbt_q <= '0;
      fbd_q <= '0;
    end else if (fb_fill) begin
      fbv_q <= 1'b1;
      fbt_q <= addr_q;
      fbd_q <= i_mem_rdata;
    end else if (fb_kill) begin
      fbv_q <= 1'b0;
    end
  end
`else
  assign fb_hit  = 1'b0;
  assign fb_data = '0;
`endif

  // Requests are level-held until their valid pulse, so IDLE
  // ignores the core during a pulse to avoid re-issuing it.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wt_d    = wt_q;
    rt_d    = rt_q;
    drd_d   = drd_q;
    frd_d   = frd_q;
    dv_d    = 1'b0;
    fv_d    = 1'b0;
    err_d   = err_q;
    tmo_clr = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (pulse) begin
          state_d = ST_IDLE;
        end else if (d_req) begin
          state_d = ST_D_ADDR;
          we_d    = i_d_wr_en ? MEM_WR : MEM_RD;
          addr_d  = i_d_addr;
          wdata_d = i_d_wdata;
          wt_d    = i_d_wr_type;
          rt_d    = i_d_rd_type;
          tmo_clr = 1'b1;
        end else if (i_if_req && fb_hit) begin
          fv_d  = 1'b1;
          frd_d = fb_data;
        end else if (i_if_req) begin
          state_d = ST_F_ADDR;
          we_d    = MEM_RD;
          addr_d  = i_if_addr;
          wdata_d = '0;
          wt_d    = 2'b00;
          rt_d    = RD_LW;
          tmo_clr = 1'b1;
        end
      end
      (state_q == ST_D_ADDR): begin
        if (i_mem_gnt) begin
          state_d = ST_D_RESP;
          tmo_clr = 1'b1;
        end else if (tmo_exp) begin
          state_d = ST_IDLE;
          dv_d    = 1'b1;
          drd_d   = '0;
          err_d   = 1'b1;
        end
      end
      (state_q == ST_F_ADDR): begin
        if (i_mem_gnt) begin
          state_d = ST_F_RESP;
          tmo_clr = 1'b1;
        end else if (tmo_exp) begin
          state_d = ST_IDLE;
          fv_d    = 1'b1;
          frd_d   = '0;
          err_d   = 1'b1;
        end
      end
      (state_q == ST_D_RESP): begin
        if (i_mem_rvalid) begin
          state_d = ST_IDLE;
          dv_d    = 1'b1;
          drd_d   = i_mem_rdata;
        end else if (tmo_exp) begin
          state_d = ST_IDLE;
          dv_d    = 1'b1;
          drd_d   = '0;
          err_d   = 1'b1;
        end
      end
      (state_q == ST_F_RESP): begin
        if (i_mem_rvalid) begin
          state_d = ST_IDLE;
          fv_d    = 1'b1;
          frd_d   = i_mem_rdata;
        end else if (tmo_exp) begin
          state_d = ST_IDLE;
          fv_d    = 1'b1;
          frd_d   = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wt_q    <= 2'b00;
      rt_q    <= 3'b000;
      drd_q   <= '0;
      frd_q   <= '0;
      dv_q    <= 1'b0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wt_q    <= wt_d;
      rt_q    <= rt_d;
      drd_q   <= drd_d;
      frd_q   <= frd_d;
      dv_q    <= dv_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_req     = st_addr(state_q);
  assign o_mem_we      = we_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_mem_wr_type = wt_q;
  assign o_mem_rd_type = rt_q;
  assign o_d_rdata     = drd_q;
  assign o_d_valid     = dv_q;
  assign o_if_rdata    = frd_q;
  assign o_if_valid    = fv_q;
  assign o_bus_err     = err_q;
  assign o_stall       = (i_if_req & ~fv_q) | (d_req & ~dv_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a memory
// responder, a unified reference memory and directed corner cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_d_rd_en = 1'b0;
  logic        i_d_wr_en = 1'b0;
  logic [31:0] i_d_addr = '0;
  logic [31:0] i_d_wdata = '0;
  logic [1:0]  i_d_wr_type = '0;
  logic [2:0]  i_d_rd_type = '0;
  logic [31:0] o_d_rdata;
  logic        o_d_valid;
  logic        o_stall;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [1:0]  o_mem_wr_type;
  logic [2:0]  o_mem_rd_type;
  logic        i_mem_gnt;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_if_req      (i_if_req),
    .i_if_addr     (i_if_addr),
    .o_if_rdata    (o_if_rdata),
    .o_if_valid    (o_if_valid),
    .i_d_rd_en     (i_d_rd_en),
    .i_d_wr_en     (i_d_wr_en),
    .i_d_addr      (i_d_addr),
    .i_d_wdata     (i_d_wdata),
    .i_d_wr_type   (i_d_wr_type),
    .i_d_rd_type   (i_d_rd_type),
    .o_d_rdata     (o_d_rdata),
    .o_d_valid     (o_d_valid),
    .o_stall       (o_stall),
    .o_mem_req     (o_mem_req),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_wr_type (o_mem_wr_type),
    .o_mem_rd_type (o_mem_rd_type),
    .i_mem_gnt     (i_mem_gnt),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata),
    .o_bus_err     (o_bus_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wt;
    logic [2:0]  rt;
  } bus_t;

  int n_vec = 0;
  int n_err = 0;

  bus_t        exp_bus[$];
  logic [31:0] exp_d[$];
  logic [31:0] exp_if[$];
  logic [31:0] rmem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];

  int   f_gnt = -1;
  int   f_rv = -1;
  bit   mute_next = 1'b0;
  int   hs_cnt = 0;
  int   dv_cnt = 0;
  int   last_hold = 0;
  logic gnt_ok = 1'b0;

  assign i_mem_gnt = o_mem_req & gnt_ok;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rd_slv(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Memory responder: gnt after a chosen delay, rvalid a few cycles later.
  initial begin : slave
    int   req_cnt;
    int   gnt_dly;
    int   rv_cnt;
    bit   rv_pend;
    logic [31:0] rv_data;
    bus_t held;
    bus_t cur;
    bus_t e;
    req_cnt = 0;
    gnt_dly = 0;
    rv_cnt  = 0;
    rv_pend = 1'b0;
    rv_data = '0;
    held    = '0;
    forever begin
      @(negedge clk);
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          rv_pend      = 1'b0;
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = rv_data;
        end else begin
          rv_cnt--;
        end
      end
      cur = '{o_mem_we, o_mem_addr, o_mem_wdata,
              o_mem_wr_type, o_mem_rd_type};
      if (o_mem_req) begin
        if (req_cnt == 0) begin
          held    = cur;
          gnt_dly = (f_gnt >= 0) ? f_gnt : int'($urandom_range(0, 4));
        end else begin
          n_vec++;
          if (cur !== held) begin
            n_err++;
            $display("FAIL req_stable: got %h required %h", cur, held);
          end
        end
        if (req_cnt >= gnt_dly) begin
          gnt_ok = 1'b1;
          n_vec++;
          if (exp_bus.size() == 0) begin
            n_err++;
            $display("FAIL bus_unexpected: got addr %h required none",
                     cur.addr);
          end else begin
            e = exp_bus.pop_front();
            chk32("bus_we", 32'(cur.we), 32'(e.we));
            chk32("bus_addr", cur.addr, e.addr);
            chk32("bus_rd_type", 32'(cur.rt), 32'(e.rt));
            if (e.we) begin
              chk32("bus_wdata", cur.wdata, e.wdata);
              chk32("bus_wr_type", 32'(cur.wt), 32'(e.wt));
            end
          end
          if (cur.we) smem[cur.addr] = cur.wdata;
          rv_data   = cur.we ? 32'h0 : rd_slv(cur.addr);
          rv_cnt    = (f_rv >= 0) ? f_rv : int'($urandom_range(0, 3));
          rv_pend   = !mute_next;
          mute_next = 1'b0;
          last_hold = req_cnt;
          hs_cnt++;
          req_cnt   = 0;
        end else begin
          gnt_ok = 1'b0;
          req_cnt++;
        end
      end else begin
        gnt_ok  = 1'b0;
        req_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every valid pulse must match the next expectation.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (o_d_valid) begin
        dv_cnt++;
        n_vec++;
        if (exp_d.size() == 0) begin
          n_err++;
          $display("FAIL d_valid_unexpected: got rdata %h required none",
                   o_d_rdata);
        end else begin
          e = exp_d.pop_front();
          if (o_d_rdata !== e) begin
            n_err++;
            $display("FAIL d_rdata: got %h required %h", o_d_rdata, e);
          end
        end
      end
      if (o_if_valid) begin
        n_vec++;
        if (exp_if.size() == 0) begin
          n_err++;
          $display("FAIL if_valid_unexpected: got rdata %h required none",
                   o_if_rdata);
        end else begin
          e = exp_if.pop_front();
          if (o_if_rdata !== e) begin
            n_err++;
            $display("FAIL if_rdata: got %h required %h", o_if_rdata, e);
          end
        end
      end
    end
  end

  task automatic run_txn(input bit f, input bit dr, input bit dw,
                         input logic [31:0] fa,
                         input logic [31:0] da,
                         input logic [31:0] wd,
                         input logic [1:0]  wt,
                         input logic [2:0]  rt,
                         input bit tmo);
    bit fp;
    bit dp;
    int cyc;
    @(negedge clk);
    i_if_req    = f;
    i_if_addr   = fa;
    i_d_rd_en   = dr;
    i_d_wr_en   = dw;
    i_d_addr    = da;
    i_d_wdata   = wd;
    i_d_wr_type = wt;
    i_d_rd_type = rt;
    if (dr || dw) begin
      exp_bus.push_back('{dw, da, wd, wt, rt});
      if (dw) rmem[da] = wd;
      exp_d.push_back((tmo || dw) ? 32'h0 : rd_ref(da));
    end
    if (f) begin
      exp_bus.push_back('{1'b0, fa, 32'h0, 2'b00, 3'b010});
      exp_if.push_back(rd_ref(fa));
    end
    fp  = f;
    dp  = dr || dw;
    cyc = 0;
    while ((fp || dp) && cyc < 600) begin
      #1;
      chk32("stall_busy", 32'(o_stall),
            32'((fp && !o_if_valid) || (dp && !o_d_valid)));
      if (fp && o_if_valid) begin
        fp = 1'b0;
        i_if_req = 1'b0;
      end
      if (dp && o_d_valid) begin
        dp = 1'b0;
        i_d_rd_en = 1'b0;
        i_d_wr_en = 1'b0;
      end
      if (fp || dp) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (fp || dp) begin
      n_vec++;
      n_err++;
      $display("FAIL txn_timeout: got no valid in %0d cycles required one",
               cyc);
      i_if_req  = 1'b0;
      i_d_rd_en = 1'b0;
      i_d_wr_en = 1'b0;
      exp_bus.delete();
      exp_d.delete();
      exp_if.delete();
    end
    @(negedge clk);
    #1;
    chk32("stall_after", 32'(o_stall), 32'h0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk32({nm, "_ctrl"},
          32'({o_mem_req, o_mem_we, o_d_valid, o_if_valid,
               o_stall, o_bus_err, o_mem_wr_type, o_mem_rd_type}),
          32'h0);
    chk32({nm, "_addr"}, o_mem_addr, 32'h0);
    chk32({nm, "_wdata"}, o_mem_wdata, 32'h0);
    chk32({nm, "_d_rdata"}, o_d_rdata, 32'h0);
    chk32({nm, "_if_rdata"}, o_if_rdata, 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] pool_f;
    logic [31:0] pool_d;
    int k;
    int h0;
    int dv0;
    int cyc;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b1;

    rmem[32'h100] = 32'h0050_0093;
    smem[32'h100] = 32'h0050_0093;
    f_gnt = 0;
    f_rv  = 1;
    run_txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 2'b00, 3'b000, 0);

    f_gnt = -1;
    f_rv  = -1;
    run_txn(1, 1, 0, 32'h104, 32'h2000, 32'h0, 2'b00, 3'b100, 0);
    run_txn(0, 0, 1, 32'h0, 32'h3004, 32'hDEAD_BEEF, 2'b10, 3'b000, 0);

    f_gnt = 4;
    run_txn(0, 1, 0, 32'h0, 32'h3004, 32'h0, 2'b00, 3'b010, 0);
    chk32("gnt_hold", 32'(last_hold), 32'd4);
    f_gnt = -1;

    for (int i = 0; i < 150; i++) begin
      k      = int'($urandom_range(0, 4));
      pool_f = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
      pool_d = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
      run_txn(k == 0 || k == 3 || k == 4, k == 1 || k == 3,
              k == 2 || k == 4, pool_f, pool_d, $urandom,
              2'($urandom), 3'($urandom), 0);
    end

    chk32("err_before", 32'(o_bus_err), 32'h0);
    mute_next = 1'b1;
    run_txn(0, 1, 0, 32'h0, 32'h2010, 32'h0, 2'b00, 3'b010, 1);
    chk32("err_timeout", 32'(o_bus_err), 32'h1);
    run_txn(1, 1, 0, 32'h2014, 32'h2018, 32'h0, 2'b00, 3'b001, 0);
    chk32("err_sticky", 32'(o_bus_err), 32'h1);

    f_gnt = 0;
    f_rv  = 10;
    @(negedge clk);
    i_d_rd_en   = 1'b1;
    i_d_addr    = 32'h2008;
    i_d_rd_type = 3'b010;
    exp_bus.push_back('{1'b0, 32'h2008, 32'h0, 2'b00, 3'b010});
    h0  = hs_cnt;
    cyc = 0;
    while (hs_cnt == h0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk32("rst_mid_hs", 32'(hs_cnt - h0), 32'h1);
    @(negedge clk);
    rst       = 1'b0;
    i_d_rd_en = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst_mid");
    rst = 1'b1;
    dv0 = dv_cnt;
    repeat (20) @(negedge clk);
    chk32("stray_rvalid", 32'(dv_cnt - dv0), 32'h0);
    f_gnt = -1;
    f_rv  = -1;

    run_txn(1, 1, 0, 32'h2000, 32'h2004, 32'h0, 2'b00, 3'b010, 0);
    chk32("err_cleared", 32'(o_bus_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
